// File: rtl/sysid_ctrl_pkg.sv
// Shared types and constants for the system-ID boot checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sysid_ctrl_pkg;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 8;
  localparam int RETRY_W = 4;

  // Word addresses of the system-ID slave
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_CMP,
    ST_GAP,
    ST_DONE
  } sysid_state_t;

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only control port towards the system-ID slave.
// Latency: readdata valid a fixed number of cycles after read/address.
// Backpressure: none; the slave never stalls, the master holds the request.
interface sysid_boot_checker_if
  import sysid_ctrl_pkg::*;
  ();

  logic              address;
  logic              read;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address,
    output read,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output readdata
  );

endinterface

// File: rtl/sysid_wait_counter.sv
// Loadable down-counter timing both the read-latency hold and the retry gap.
// Latency: zero flag reflects the registered count (load value visible next cycle).
// Backpressure: none; load has priority over counting, count stops at zero.
module sysid_wait_counter
  import sysid_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on state entry, otherwise count down and park at zero
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot sequencer: reads sysid ID/timestamp words, compares, retries, reports sticky pass/fail.
// Latency: done/pass at 2L+4 cycles after start, plus 2L+3+RETRY_GAP per retry.
// Backpressure: none; start is ignored unless idle, slave latency is fixed.
module sysid_boot_checker
  import sysid_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1626704057,
  parameter int unsigned       READ_LATENCY       = 1,
  parameter int unsigned       MAX_RETRIES        = 3,
  parameter int unsigned       RETRY_GAP          = 8,
  parameter bit                AUTO_START         = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  sysid_boot_checker_if.master sysid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 id_ok,
  output logic                 ts_ok,
  output logic [RETRY_W-1:0]   retry_count,
  output logic [DATA_W-1:0]    captured_id,
  output logic [DATA_W-1:0]    captured_ts
);

  // Read phases last L+1 cycles, so the counter starts at L; the gap starts at G-1
  localparam logic [CNT_W-1:0]   LAT_LOAD  = CNT_W'(READ_LATENCY);
  localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(RETRY_GAP - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  sysid_state_t     state;
  logic             auto_pend;
  logic             trigger;
  logic             both_ok;
  logic             can_retry;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  assign trigger   = start | auto_pend;
  assign both_ok   = (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TIMESTAMP);
  // retry_count only ever steps by one from zero, so inequality is the bound
  assign can_retry = (retry_count != RETRY_MAX);

  // Load the shared wait counter on entry to each timed state
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = LAT_LOAD;
    case (state)
      ST_IDLE:  cnt_load = trigger;
      ST_RD_ID: cnt_load = cnt_zero;
      ST_CMP: begin
        if (!both_ok && can_retry) begin
          cnt_load = 1'b1;
          cnt_val  = GAP_LOAD;
        end
      end
      ST_GAP:   cnt_load = cnt_zero;
      default:  cnt_load = 1'b0;
    endcase
  end

  sysid_wait_counter u_wait (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Sequencer state and all registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      auto_pend     <= AUTO_START;
      sysid.address <= SYSID_ADDR_ID;
      sysid.read    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      id_ok         <= 1'b0;
      ts_ok         <= 1'b0;
      retry_count   <= '0;
      captured_id   <= '0;
      captured_ts   <= '0;
    end else begin
      auto_pend <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state         <= ST_RD_ID;
            sysid.address <= SYSID_ADDR_ID;
            sysid.read    <= 1'b1;
            busy          <= 1'b1;
            pass          <= 1'b0;
            id_ok         <= 1'b0;
            ts_ok         <= 1'b0;
            retry_count   <= '0;
          end
        end
        ST_RD_ID: begin
          if (cnt_zero) begin
            captured_id   <= sysid.readdata;
            sysid.address <= SYSID_ADDR_TS;
            state         <= ST_RD_TS;
          end
        end
        ST_RD_TS: begin
          if (cnt_zero) begin
            captured_ts   <= sysid.readdata;
            sysid.address <= SYSID_ADDR_ID;
            sysid.read    <= 1'b0;
            state         <= ST_CMP;
          end
        end
        ST_CMP: begin
          id_ok <= (captured_id == EXPECTED_ID);
          ts_ok <= (captured_ts == EXPECTED_TIMESTAMP);
          if (both_ok) begin
            pass  <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else if (can_retry) begin
            retry_count <= retry_count + RETRY_W'(1);
            state       <= ST_GAP;
          end else begin
            pass  <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            sysid.address <= SYSID_ADDR_ID;
            sysid.read    <= 1'b1;
            state         <= ST_RD_ID;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomised bench for the sysid boot checker against a per-attempt outcome model.
// Latency: checks done cycle from 2L+4 + retries*(2L+3+G).
// Backpressure: start is pulsed while busy and during done to confirm it is ignored.
module tb_sysid_boot_checker;

  localparam int          L_A   = 1;
  localparam int          MR_A  = 3;
  localparam int          G_A   = 8;
  localparam logic [31:0] EID_A = 32'd0;
  localparam logic [31:0] ETS_A = 32'd1626704057;

  localparam int          L_B   = 0;
  localparam int          MR_B  = 0;
  localparam int          G_B   = 3;
  localparam logic [31:0] EID_B = 32'hCAFE0001;
  localparam logic [31:0] ETS_B = 32'h5A5A0002;

  typedef struct {
    logic        done;
    logic        busy;
    logic        pass;
    logic        id_ok;
    logic        ts_ok;
    logic        read;
    logic        address;
    logic [3:0]  retry;
    logic [31:0] cap_id;
    logic [31:0] cap_ts;
  } obs_t;

  logic clk;
  logic reset_n;
  logic start_a, start_b;
  logic busy_a, done_a, pass_a, id_ok_a, ts_ok_a;
  logic busy_b, done_b, pass_b, id_ok_b, ts_ok_b;
  logic [3:0]  retry_a, retry_b;
  logic [31:0] cap_id_a, cap_ts_a, cap_id_b, cap_ts_b;

  sysid_boot_checker_if if_a ();
  sysid_boot_checker_if if_b ();

  sysid_boot_checker dut_a (
    .clock       (clk),
    .reset_n     (reset_n),
    .start       (start_a),
    .sysid       (if_a),
    .busy        (busy_a),
    .done        (done_a),
    .pass        (pass_a),
    .id_ok       (id_ok_a),
    .ts_ok       (ts_ok_a),
    .retry_count (retry_a),
    .captured_id (cap_id_a),
    .captured_ts (cap_ts_a)
  );

  sysid_boot_checker #(
    .EXPECTED_ID        (EID_B),
    .EXPECTED_TIMESTAMP (ETS_B),
    .READ_LATENCY       (L_B),
    .MAX_RETRIES        (MR_B),
    .RETRY_GAP          (G_B),
    .AUTO_START         (1'b0)
  ) dut_b (
    .clock       (clk),
    .reset_n     (reset_n),
    .start       (start_b),
    .sysid       (if_b),
    .busy        (busy_b),
    .done        (done_b),
    .pass        (pass_b),
    .id_ok       (id_ok_b),
    .ts_ok       (ts_ok_b),
    .retry_count (retry_b),
    .captured_id (cap_id_b),
    .captured_ts (cap_ts_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc;
  int          rd [2];
  logic [31:0] id_tab [2][16];
  logic [31:0] ts_tab [2][16];
  obs_t        obs [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_start(input int sel, input logic v);
    if (sel == 0) start_a = v;
    else          start_b = v;
  endtask

  // Advance one cycle; the slave answers from the attempt's table entry
  task automatic step();
    int att;
    @(posedge clk);
    #1;
    cyc++;
    att = rd[0] / (2 * (L_A + 1));
    if (att > 15) att = 15;
    if_a.readdata = if_a.address ? ts_tab[0][att] : id_tab[0][att];
    if (if_a.read) rd[0]++;
    att = rd[1] / (2 * (L_B + 1));
    if (att > 15) att = 15;
    if_b.readdata = if_b.address ? ts_tab[1][att] : id_tab[1][att];
    if (if_b.read) rd[1]++;
    obs[0] = '{done_a, busy_a, pass_a, id_ok_a, ts_ok_a, if_a.read, if_a.address,
               retry_a, cap_id_a, cap_ts_a};
    obs[1] = '{done_b, busy_b, pass_b, id_ok_b, ts_ok_b, if_b.read, if_b.address,
               retry_b, cap_id_b, cap_ts_b};
  endtask

  task automatic good_tables(input int sel);
    for (int a = 0; a < 16; a++) begin
      id_tab[sel][a] = (sel == 0) ? EID_A : EID_B;
      ts_tab[sel][a] = (sel == 0) ? ETS_A : ETS_B;
    end
  endtask

  task automatic rand_tables(input int sel);
    for (int a = 0; a < 16; a++) begin
      id_tab[sel][a] = ($urandom_range(0, 3) != 0) ? ((sel == 0) ? EID_A : EID_B) : $urandom();
      ts_tab[sel][a] = ($urandom_range(0, 3) != 0) ? ((sel == 0) ? ETS_A : ETS_B) : $urandom();
    end
  endtask

  task automatic chk_reset(input int sel);
    string p;
    p = (sel == 0) ? "A." : "B.";
    chk({p, "rst_ctl"}, {21'd0, obs[sel].done, obs[sel].busy, obs[sel].pass, obs[sel].id_ok,
                         obs[sel].ts_ok, obs[sel].read, obs[sel].address, obs[sel].retry}, 32'd0);
    chk({p, "rst_cap"}, obs[sel].cap_id | obs[sel].cap_ts, 32'd0);
  endtask

  // One full check: trigger, track to done, compare with the attempt-level model
  task automatic run_check(input int sel, input bit auto_rel, input bit noise);
    int          lat, mr, gap, k, exp_cyc, exp_rd, done_cyc, busy_bad, addr_bad;
    int          extra_done, extra_busy;
    logic [31:0] eid, ets;
    bit          ok;
    string       p;
    p   = (sel == 0) ? "A." : "B.";
    lat = (sel == 0) ? L_A : L_B;
    mr  = (sel == 0) ? MR_A : MR_B;
    gap = (sel == 0) ? G_A : G_B;
    eid = (sel == 0) ? EID_A : EID_B;
    ets = (sel == 0) ? ETS_A : ETS_B;
    // First attempt whose both words match, else the last allowed attempt
    k  = mr;
    ok = 1'b0;
    for (int a = 0; a <= mr; a++) begin
      if (!ok && id_tab[sel][a] == eid && ts_tab[sel][a] == ets) begin
        k  = a;
        ok = 1'b1;
      end
    end
    exp_cyc = 2 * lat + 4 + k * (2 * lat + 3 + gap);
    exp_rd  = (k + 1) * 2 * (lat + 1);

    rd[sel] = 0;
    cyc     = 0;
    if (auto_rel) reset_n = 1'b1;
    else          drive_start(sel, 1'b1);
    step();
    drive_start(sel, 1'b0);
    done_cyc = -1;
    busy_bad = 0;
    addr_bad = 0;
    for (int t = 0; t < 400; t++) begin
      if (obs[sel].done) begin
        done_cyc = cyc;
        break;
      end
      if (!obs[sel].busy) busy_bad++;
      if (obs[sel].address && !obs[sel].read) addr_bad++;
      drive_start(sel, noise ? 1'($urandom_range(0, 1)) : 1'b0);
      step();
    end
    chk({p, "done_cycle"}, done_cyc, exp_cyc);
    chk({p, "busy_at_done"}, {31'd0, obs[sel].busy}, 32'd0);
    chk({p, "busy_gaps"}, busy_bad, 0);
    chk({p, "addr_idle"}, addr_bad, 0);
    chk({p, "pass"}, {31'd0, obs[sel].pass}, {31'd0, ok});
    chk({p, "id_ok"}, {31'd0, obs[sel].id_ok}, {31'd0, id_tab[sel][k] == eid});
    chk({p, "ts_ok"}, {31'd0, obs[sel].ts_ok}, {31'd0, ts_tab[sel][k] == ets});
    chk({p, "retry_count"}, {28'd0, obs[sel].retry}, k);
    chk({p, "captured_id"}, obs[sel].cap_id, id_tab[sel][k]);
    chk({p, "captured_ts"}, obs[sel].cap_ts, ts_tab[sel][k]);
    chk({p, "read_cycles"}, rd[sel], exp_rd);

    // start in the done cycle must not launch another check
    drive_start(sel, noise);
    step();
    drive_start(sel, 1'b0);
    extra_done = 0;
    extra_busy = 0;
    for (int t = 0; t < 2 * lat + 6; t++) begin
      if (obs[sel].done) extra_done++;
      if (obs[sel].busy) extra_busy++;
      step();
    end
    chk({p, "extra_done"}, extra_done, 0);
    chk({p, "extra_busy"}, extra_busy, 0);
    chk({p, "pass_held"}, {31'd0, obs[sel].pass}, {31'd0, ok});
  endtask

  initial begin
    reset_n       = 1'b0;
    start_a       = 1'b0;
    start_b       = 1'b0;
    if_a.readdata = '0;
    if_b.readdata = '0;
    rd[0]         = 0;
    rd[1]         = 0;
    cyc           = 0;
    good_tables(0);
    good_tables(1);
    repeat (3) step();
    chk_reset(0);
    chk_reset(1);

    // Auto-start on reset release, clean slave
    run_check(0, 1'b1, 1'b0);

    // Timestamp always wrong: all retries consumed
    for (int a = 0; a < 16; a++) ts_tab[0][a] = 32'h12345678;
    run_check(0, 1'b0, 1'b0);

    // Wrong ID for two attempts, then correct
    good_tables(0);
    id_tab[0][0] = 32'hDEAD0001;
    id_tab[0][1] = 32'hDEAD0002;
    run_check(0, 1'b0, 1'b0);

    // Reset while reading the timestamp word
    good_tables(0);
    rd[0]   = 0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    chk("A.in_rd_ts", {30'd0, obs[0].read, obs[0].address}, 32'd3);
    reset_n = 1'b0;
    step();
    chk_reset(0);
    step();
    chk("A.no_done_in_reset", {31'd0, obs[0].done}, 32'd0);
    run_check(0, 1'b1, 1'b0);

    // start hammered while busy and at done
    run_check(0, 1'b0, 1'b1);

    // Zero latency, single attempt, mismatch
    good_tables(1);
    ts_tab[1][0] = 32'h0BAD0BAD;
    run_check(1, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      int sel;
      sel = (i % 3 == 2) ? 1 : 0;
      rand_tables(sel);
      run_check(sel, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
